// File: rtl/bnn_sequencer_if.sv
// Control, image-buffer read, weight-ROM read and result signals of the BNN sequencer.
// The master modport is the sequencer; the slave modport is the controller and memories.
interface bnn_sequencer_if;
  logic       start;
  logic       clear;
  logic       buf_rd_en;
  logic [6:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic       w_rd_en;
  logic [9:0] w_rd_addr;
  logic [7:0] w_rd_data;
  logic       busy;
  logic       result_ready;
  logic [3:0] result_class;
  logic [9:0] result_score;

  modport master (
    input  start, clear, buf_rd_data, w_rd_data,
    output buf_rd_en, buf_rd_addr, w_rd_en, w_rd_addr,
    output busy, result_ready, result_class, result_score
  );

  modport slave (
    output start, clear, buf_rd_data, w_rd_data,
    input  buf_rd_en, buf_rd_addr, w_rd_en, w_rd_addr,
    input  busy, result_ready, result_class, result_score
  );
endinterface

// File: rtl/bnn_sequencer.sv
// Binarised classifier sequencer: XNOR-popcount of the image against each class's
// weights, one class per IMG_BYTES+2 cycles, keeping the best (lowest index on ties).
module bnn_sequencer #(
  parameter int IMG_BYTES   = 98,
  parameter int NUM_CLASSES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  bnn_sequencer_if.master  bus,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [6:0] LAST_B = 7'(IMG_BYTES - 1);
  localparam logic [3:0] LAST_C = 4'(NUM_CLASSES - 1);
  localparam logic [9:0] STRIDE = 10'(IMG_BYTES);

  state_t     state;
  logic [3:0] c;
  logic [6:0] b;
  logic [9:0] w_base;
  logic [9:0] acc;
  logic       rd_vld;
  logic [9:0] best_score;
  logic [3:0] best_class;
  logic       result_ready;
  logic [3:0] result_class;
  logic [9:0] result_score;

  function automatic logic [3:0] match_count(input logic [7:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, x[i]};
    return n;
  endfunction

  logic [7:0] xnor_bits;
  logic [9:0] acc_next;
  logic       take;
  logic [9:0] new_best_score;
  logic [3:0] new_best_class;

  always_comb begin
    xnor_bits      = ~(bus.buf_rd_data ^ bus.w_rd_data);
    acc_next       = rd_vld ? (acc + {6'b0, match_count(xnor_bits)}) : acc;
    // Strict greater-than keeps the earlier class on equal scores.
    take           = (c == 4'd0) || (acc > best_score);
    new_best_score = take ? acc : best_score;
    new_best_class = take ? c : best_class;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      c            <= '0;
      b            <= '0;
      w_base       <= '0;
      acc          <= '0;
      rd_vld       <= 1'b0;
      best_score   <= '0;
      best_class   <= '0;
      result_ready <= 1'b0;
      result_class <= '0;
      result_score <= '0;
    end else if (bus.clear) begin
      // Dropping rd_vld discards any data return that lands this cycle.
      state        <= S_IDLE;
      c            <= '0;
      b            <= '0;
      w_base       <= '0;
      acc          <= '0;
      rd_vld       <= 1'b0;
      best_score   <= '0;
      best_class   <= '0;
      result_ready <= 1'b0;
      result_class <= '0;
      result_score <= '0;
    end else begin
      rd_vld <= (state == S_RUN);
      acc    <= acc_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            c            <= '0;
            b            <= '0;
            w_base       <= '0;
            acc          <= '0;
            result_ready <= 1'b0;
            result_class <= '0;
            result_score <= '0;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          b <= b + 7'd1;
          if (b == LAST_B) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_CMP;
        S_CMP: begin
          best_score <= new_best_score;
          best_class <= new_best_class;
          acc        <= '0;
          b          <= '0;
          if (c == LAST_C) begin
            result_ready <= 1'b1;
            result_class <= new_best_class;
            result_score <= new_best_score;
            state        <= S_DONE;
          end else begin
            c      <= c + 4'd1;
            w_base <= w_base + STRIDE;
            state  <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic run;
  assign run              = (state == S_RUN);
  assign bus.buf_rd_en    = run;
  assign bus.w_rd_en      = run;
  assign bus.buf_rd_addr  = run ? b : 7'd0;
  assign bus.w_rd_addr    = run ? (w_base + {3'b000, b}) : 10'd0;
  assign bus.busy         = (state == S_RUN) || (state == S_DRAIN) || (state == S_CMP);
  assign bus.result_ready = result_ready;
  assign bus.result_class = result_class;
  assign bus.result_score = result_score;
  assign dbg_state        = state;

endmodule

// File: tb/tb_bnn_sequencer.sv
// Directed bench for bnn_sequencer with behavioural image buffer and weight ROM.
module tb_bnn_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  logic [7:0] img [0:97];
  logic [7:0] wt  [0:979];

  always #5 clk = ~clk;

  bnn_sequencer_if bus();

  bnn_sequencer #(.IMG_BYTES(98), .NUM_CLASSES(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (bus.buf_rd_en) bus.buf_rd_data <= img[bus.buf_rd_addr];
    if (bus.w_rd_en)   bus.w_rd_data   <= wt[bus.w_rd_addr];
  end

  task automatic fill_img(input logic [7:0] v);
    for (int i = 0; i < 98; i++) img[i] = v;
  endtask

  task automatic fill_class(input int cls, input logic [7:0] v);
    for (int i = 0; i < 98; i++) wt[cls*98 + i] = v;
  endtask

  // Leaves the bench #1 after the edge that sampled start.
  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.result_ready && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.busy, bus.result_ready, bus.buf_rd_en, bus.w_rd_en, bus.buf_rd_addr,
         bus.w_rd_addr, bus.result_class, bus.result_score} !== 35'd0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
    end
    total++;
    if (dbg_state !== 3'd0) begin
      bad++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_one_class();
    int cyc;
    fill_img(8'h00);
    for (int k = 0; k < 10; k++) fill_class(k, (k == 3) ? 8'h00 : 8'hFF);
    pulse_start();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %0b want 1", bus.busy); end
    cyc = 0;
    while (!bus.result_ready && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 97) begin
        total++;
        if ({bus.buf_rd_en, bus.buf_rd_addr, bus.w_rd_addr} !== {1'b1, 7'd97, 10'd97}) begin
          bad++; $display("FAIL last_issue: en=%0b baddr=%0d waddr=%0d want 1/97/97",
                          bus.buf_rd_en, bus.buf_rd_addr, bus.w_rd_addr);
        end
      end
      if (cyc == 98) begin
        total++;
        if ({bus.buf_rd_en, bus.w_rd_en, bus.busy} !== 3'b001) begin
          bad++; $display("FAIL drain_strobes: en=%0b/%0b busy=%0b want 0/0/1",
                          bus.buf_rd_en, bus.w_rd_en, bus.busy);
        end
      end
      if (cyc == 100) begin
        total++;
        if ({bus.w_rd_en, bus.w_rd_addr} !== {1'b1, 10'd98}) begin
          bad++; $display("FAIL class1_first_addr: got %0d want 98", bus.w_rd_addr);
        end
      end
    end
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL one_class_latency: got %0d want 1000", cyc); end
    total++;
    if (bus.result_class !== 4'd3) begin bad++; $display("FAIL one_class_class: got %0d want 3", bus.result_class); end
    total++;
    if (bus.result_score !== 10'd784) begin bad++; $display("FAIL one_class_score: got %0d want 784", bus.result_score); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_identical();
    int cyc;
    for (int i = 0; i < 98; i++) img[i] = 8'((i * 37) + 5);
    for (int k = 0; k < 10; k++)
      for (int i = 0; i < 98; i++) wt[k*98 + i] = img[i];
    pulse_start();
    wait_result(cyc);
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL identical_latency: got %0d want 1000", cyc); end
    total++;
    if (bus.result_class !== 4'd0) begin bad++; $display("FAIL identical_class: got %0d want 0", bus.result_class); end
    total++;
    if (bus.result_score !== 10'd784) begin bad++; $display("FAIL identical_score: got %0d want 784", bus.result_score); end
  endtask

  task automatic test_half();
    int cyc;
    fill_img(8'hAA);
    for (int k = 0; k < 10; k++) fill_class(k, 8'h0F);
    pulse_start();
    cyc = 0;
    while (!bus.result_ready && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 205) begin
        total++;
        if ({bus.w_rd_addr, bus.buf_rd_addr} !== {10'd201, 7'd5}) begin
          bad++; $display("FAIL addr_c2_b5: waddr=%0d baddr=%0d want 201/5", bus.w_rd_addr, bus.buf_rd_addr);
        end
      end
    end
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL half_latency: got %0d want 1000", cyc); end
    total++;
    if (bus.result_class !== 4'd0) begin bad++; $display("FAIL half_class: got %0d want 0", bus.result_class); end
    total++;
    if (bus.result_score !== 10'd392) begin bad++; $display("FAIL half_score: got %0d want 392", bus.result_score); end
  endtask

  // Classes 4 and 7 tie at 686 (7 of 8 bits match), class 6 scores 588, rest 0.
  task automatic test_partial_tie();
    int cyc;
    fill_img(8'h00);
    for (int k = 0; k < 10; k++) fill_class(k, 8'hFF);
    fill_class(4, 8'h01);
    fill_class(7, 8'h01);
    fill_class(6, 8'h03);
    pulse_start();
    wait_result(cyc);
    total++;
    if (bus.result_class !== 4'd4) begin bad++; $display("FAIL tie_class: got %0d want 4", bus.result_class); end
    total++;
    if (bus.result_score !== 10'd686) begin bad++; $display("FAIL tie_score: got %0d want 686", bus.result_score); end
  endtask

  task automatic test_clear();
    int cyc;
    int seen;
    pulse_start();
    cyc = 0;
    while (cyc < 500) begin @(posedge clk); #1; cyc++; end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    cyc++;
    bus.clear = 1'b0;
    total++;
    if ({bus.busy, bus.buf_rd_en, bus.w_rd_en, bus.result_ready} !== 4'b0000) begin
      bad++; $display("FAIL clear_outputs: busy=%0b en=%0b/%0b rdy=%0b want 0",
                      bus.busy, bus.buf_rd_en, bus.w_rd_en, bus.result_ready);
    end
    total++;
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL clear_state: got %0d want 0", dbg_state); end
    seen = 0;
    while (cyc < 1100) begin
      @(posedge clk); #1; cyc++;
      if (bus.result_ready || bus.busy || bus.buf_rd_en) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL clear_quiet: got %0d active cycles want 0", seen); end
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    total++;
    if ({bus.busy, dbg_state} !== 4'd0) begin
      bad++; $display("FAIL clear_wins: busy=%0b state=%0d want 0/0", bus.busy, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_img(8'h00);
    for (int k = 0; k < 10; k++) fill_class(k, (k == 3) ? 8'h00 : 8'hFF);
    pulse_start();
    cyc = 0;
    while (!bus.result_ready && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 299) bus.start = 1'b1;
      if (cyc == 300) begin
        bus.start = 1'b0;
        total++;
        if ({bus.buf_rd_addr, bus.w_rd_addr} !== {7'd0, 10'd294}) begin
          bad++; $display("FAIL busy_start_ignored: baddr=%0d waddr=%0d want 0/294",
                          bus.buf_rd_addr, bus.w_rd_addr);
        end
      end
    end
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL restart_latency: got %0d want 1000", cyc); end
    total++;
    if (bus.result_class !== 4'd3) begin bad++; $display("FAIL restart_class: got %0d want 3", bus.result_class); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.result_ready !== 1'b1) begin bad++; $display("FAIL result_hold: got %0b want 1", bus.result_ready); end
    fill_class(3, 8'hFF);
    fill_class(8, 8'h00);
    pulse_start();
    total++;
    if ({bus.result_ready, bus.busy} !== 2'b01) begin
      bad++; $display("FAIL done_restart: rdy=%0b busy=%0b want 0/1", bus.result_ready, bus.busy);
    end
    wait_result(cyc);
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL second_latency: got %0d want 1000", cyc); end
    total++;
    if ({bus.result_class, bus.result_score} !== {4'd8, 10'd784}) begin
      bad++; $display("FAIL second_result: class=%0d score=%0d want 8/784", bus.result_class, bus.result_score);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int strobes;
    pulse_start();
    cyc = 0;
    while (cyc < 400) begin @(posedge clk); #1; cyc++; end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.result_ready, bus.buf_rd_en, bus.w_rd_en, bus.buf_rd_addr,
         bus.w_rd_addr, bus.result_class, bus.result_score, dbg_state} !== 38'd0) begin
      bad++; $display("FAIL async_reset: busy=%0b en=%0b waddr=%0d state=%0d want all 0",
                      bus.busy, bus.buf_rd_en, bus.w_rd_addr, dbg_state);
    end
    strobes = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.buf_rd_en || bus.w_rd_en) strobes++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.buf_rd_en || bus.w_rd_en || bus.busy) strobes++;
    end
    total++;
    if (strobes !== 0) begin bad++; $display("FAIL reset_quiet: got %0d active cycles want 0", strobes); end
    pulse_start();
    wait_result(cyc);
    total++;
    if (cyc !== 1000) begin bad++; $display("FAIL post_reset_latency: got %0d want 1000", cyc); end
    total++;
    if ({bus.result_class, bus.result_score} !== {4'd8, 10'd784}) begin
      bad++; $display("FAIL post_reset_result: class=%0d score=%0d want 8/784", bus.result_class, bus.result_score);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    for (int i = 0; i < 98; i++) img[i] = 8'h00;
    for (int i = 0; i < 980; i++) wt[i] = 8'h00;
    test_reset();
    test_one_class();
    test_identical();
    test_half();
    test_partial_tie();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bnn_sequencer.md
BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 Parameter IMG_BYTES, default 98, image length in bytes (28x28 bits).
REQ-002 Parameter NUM_CLASSES, default 10, number of output classes.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse requesting inference; comes from the controller's bnn_enable.
REQ-006 clear  in  1  abort and return to idle.
REQ-007 buf_rd_en  out  1  image buffer read strobe.
REQ-008 buf_rd_addr  out  7  image buffer byte address.
REQ-009 buf_rd_data  in  8  image byte; valid 1 cycle after the strobe.
REQ-010 w_rd_en  out  1  weight ROM read strobe.
REQ-011 w_rd_addr  out  10  weight ROM byte address.
REQ-012 w_rd_data  in  8  weight byte; valid 1 cycle after the strobe.
REQ-013 busy  out  1  high while an inference is in progress.
REQ-014 result_ready  out  1  level; high while a result is held.
REQ-015 result_class  out  4  winning class index.
REQ-016 result_score  out  10  winning match count, range 0..784.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN, CMP and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load class counter c=0 and byte counter b=0, clear the accumulator, clear result_ready and enter RUN.
REQ-019 In RUN, buf_rd_en and w_rd_en SHALL be 1 every cycle, with buf_rd_addr=b and w_rd_addr=c*IMG_BYTES+b; b then increments.
REQ-020 When b=IMG_BYTES-1 is issued, the next state SHALL be DRAIN; the read strobes SHALL be 0 in every state other than RUN.
REQ-021 A 1-cycle valid delay SHALL track each issued read; when set, the accumulator SHALL add popcount(~(buf_rd_data ^ w_rd_data)), range 0..8.
REQ-022 The accumulator SHALL be 10 bits wide and SHALL NOT overflow (maximum 784).
REQ-023 DRAIN SHALL last 1 cycle, absorbing the final data return, then go to CMP.
REQ-024 In CMP, if c=0 or acc > best_score, the block SHALL set best_score=acc and best_class=c; ties keep the lower index.
REQ-025 CMP SHALL then clear acc and b; if c=NUM_CLASSES-1 it SHALL go to DONE, otherwise it SHALL increment c and go to RUN.
REQ-026 Each class SHALL take exactly IMG_BYTES+2 cycles.
REQ-027 result_ready SHALL go high exactly NUM_CLASSES*(IMG_BYTES+2) cycles (1000 by default) after the edge that sampled start.
REQ-028 On entering DONE, result_ready SHALL be 1 and result_class/result_score SHALL equal best_class/best_score; they hold until start, clear or reset.
REQ-029 busy SHALL be 1 in RUN, DRAIN and CMP, and 0 in IDLE and DONE.
REQ-030 start while busy=1 SHALL be ignored: no restart and no counter change.
REQ-031 clear=1 in any state SHALL, on the next edge, enter IDLE and zero c, b, acc, the valid delay, best_*, result_* and result_ready.
REQ-032 clear and start asserted in the same cycle: clear SHALL win, and the block stays in IDLE.
REQ-033 A data return arriving in the cycle clear is sampled SHALL be discarded.
REQ-034 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE with busy=0, result_ready=0, result_class=0, result_score=0, buf_rd_en=0, w_rd_en=0, buf_rd_addr=0, w_rd_addr=0, and internal counters and accumulators zero.
REQ-036 Reset asserted mid-RUN SHALL abort immediately, with no further read strobes; after release, the block SHALL wait in IDLE for a fresh start.

Verification
REQ-037 Image all 0x00; class 3 weights all 0x00, others all 0xFF; pulse start -> result_ready rises exactly 1000 cycles later, with result_class=3 and result_score=784.
REQ-038 Every class has weights identical to the image -> result_class=0 (tie rule) and result_score=784.
REQ-039 Image 0xAA; all weights 0x0F -> every class scores 392, result_class=0; also check w_rd_addr=201 when c=2, b=5.
REQ-040 clear pulsed 500 cycles after start -> the next cycle shows busy=0, no strobes, and result_ready stays 0 through cycle 1100.
REQ-041 start re-pulsed at cycle 300 -> ignored, and the result still arrives at cycle 1000. start pulsed in DONE -> result_ready=0 next cycle, and a new result arrives 1000 cycles later.
REQ-042 rst_n asserted at cycle 400 -> all outputs equal their REQ-035 values immediately (asynchronously); a fresh start after release completes normally.
